sw_debounce: RTL

Front-end conditioning stage for the board slide switches: synchronises the raw asynchronous switch inputs into the clock domain, debounces each bit independently, and presents a clean, stable switch vector plus per-bit edge pulses. Its `sw_stable` output drives the `sw` input of the switch-to-LED stage directly, so LEDs only change on settled switch positions.

---
 rtl/sw_pkg.sv | 13 +
 rtl/sw_debounce_bit.sv | 57 +++++
 rtl/sw_debounce.sv | 44 ++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared switch-path constants used by the debouncer, the switch-to-LED stage and the top level.
package sw_pkg;

    localparam int                  SW_WIDTH           = 8;
    localparam int                  SW_DEBOUNCE_CYCLES = 16;
    localparam logic [SW_WIDTH-1:0] SW_RESET_VAL       = '0;

    // Qualification counter width; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, qualification counter, stable flop and edge pulses.
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic qualify
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // High on the edge where the disagreement has lasted DEBOUNCE_CYCLES samples.
    assign qualify = (sync2 != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            if (sync2 == stable || qualify) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (qualify) begin
                stable <= sync2;
            end
            rise <= qualify & sync2;
            fall <= qualify & ~sync2;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioning: per-bit synchronise + debounce, with a shared any-edge pulse.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int               WIDTH           = SW_WIDTH,
    parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL       = WIDTH'(SW_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] qualify;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (sw_raw[i]),
            .stable  (sw_stable[i]),
            .rise    (sw_rise[i]),
            .fall    (sw_fall[i]),
            .qualify (qualify[i])
        );
    end

    // Registered from the per-bit qualify terms so it lines up with sw_rise/sw_fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |qualify;
        end
    end

endmodule
